// File: rtl/rx_ring_ctrl.sv
// rx_ring_ctrl
//   Frame-aware controller that runs the RX_RING simple dual-port RAM as a
//   packet FIFO. Words from the RX MAC are written as they arrive. A frame
//   only becomes visible to the read side once its last word has arrived
//   without an error. Errored or oversize frames are rewound. Committed words
//   are replayed through a 2-entry output buffer at one word per cycle.
//
// Ports
//   clk, rst_n            single clock (both RAM ports), async active-low reset
//   flush                 sync clear of pointers, output buffer, sideband (not counters)
//   in_*                  input stream from the MAC (valid/ready)
//   out_*                 output stream to CPU/DMA (valid/ready)
//   ram_wr_*              RX_RING write port (byte-lane enables)
//   ram_rd_addr/rd_data   RX_RING read port, data valid one cycle after address
//   level                 committed words not yet read from the RAM
//   drop_cnt, ovf_cnt     saturating counts of errored / oversize frames
//   dbg_state             write FSM state (0 IDLE, 1 FRAME, 2 DROP)
//
// Handshake: a word moves on an interface in every cycle where valid and ready
// are both high at the rising clock edge. valid never depends on ready; in_ready
// may depend on in_valid (an oversize word is taken so it can be discarded).
module rx_ring_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 48,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [2:0]          in_nbytes,
  input  logic                in_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [2:0]          out_nbytes,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [DATA_W-1:0]   ram_wr_data,
  output logic [DATA_W/8-1:0] ram_wr_be,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [DATA_W-1:0]   ram_rd_data,
  output logic [ADDR_W:0]     level,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic [1:0]          dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W:0] FULL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      NB_FULL = 3'(BE_W);

  typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DROP = 2'd2} state_t;

  state_t            state;
  logic [ADDR_W:0]   wr_ptr, cmt_ptr, rd_ptr;
  logic [ADDR_W:0]   wr_used, frm_used;
  logic              ovf_hit, accept, wr_fire;

  // Sideband per RAM entry: last flag and byte count of that word.
  logic              sb_last [DEPTH];
  logic [2:0]        sb_nb   [DEPTH];

  // Read side.
  logic              rd_pend;
  logic              rd_last_q;
  logic [2:0]        rd_nb_q;
  logic [1:0]        buf_cnt;
  logic              buf_hd;
  logic [DATA_W-1:0] buf_data [2];
  logic              buf_last [2];
  logic [2:0]        buf_nb   [2];
  logic              pop, issue;
  logic [1:0]        occ;

  assign wr_used  = wr_ptr - rd_ptr;
  assign frm_used = wr_ptr - cmt_ptr;

  // The current frame already fills the whole ring and another word arrives:
  // the frame can never be committed. The word is taken and thrown away. A
  // last word in that position ends the frame as well, so the sender is never
  // stalled forever on a frame that cannot fit.
  assign ovf_hit  = (state == FRAME) && (frm_used == FULL) && in_valid;
  assign in_ready = (wr_used != FULL) || (state == DROP) || ovf_hit;
  assign accept   = in_valid && in_ready && !flush;
  assign wr_fire  = accept && (state != DROP) && !ovf_hit;

  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
  assign ram_wr_data = in_data;

  always_comb begin
    ram_wr_be = '1;
    if (in_last) begin
      for (int i = 0; i < BE_W; i++) ram_wr_be[i] = (i < int'(in_nbytes));
    end
  end

  assign dbg_state = state;
  assign level     = cmt_ptr - rd_ptr;

  // Write FSM, pointers, commit, counters and sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_last[i] <= 1'b0;
        sb_nb[i]   <= '0;
      end
    end else if (flush) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_last[i] <= 1'b0;
        sb_nb[i]   <= '0;
      end
    end else begin
      if (wr_fire) begin
        sb_last[wr_ptr[ADDR_W-1:0]] <= in_last;
        sb_nb[wr_ptr[ADDR_W-1:0]]   <= in_last ? in_nbytes : NB_FULL;
      end
      case (state)
        IDLE, FRAME: begin
          if (ovf_hit) begin
            wr_ptr <= cmt_ptr;
            if (ovf_cnt != {CNT_W{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
            state <= in_last ? IDLE : DROP;
          end else if (wr_fire) begin
            if (!in_last) begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= FRAME;
            end else if (in_err) begin
              wr_ptr <= cmt_ptr;
              if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
              state  <= IDLE;
            end else begin
              wr_ptr  <= wr_ptr + 1'b1;
              cmt_ptr <= wr_ptr + 1'b1;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (accept && in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read side: keep buffered + in-flight words at most 2.
  assign pop         = out_valid && out_ready;
  assign occ         = buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
  assign issue       = !flush && (cmt_ptr != rd_ptr) && (occ < 2'd2);
  assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

  assign out_valid  = (buf_cnt != 2'd0);
  assign out_data   = buf_data[buf_hd];
  assign out_last   = out_valid && buf_last[buf_hd];
  assign out_nbytes = out_valid ? buf_nb[buf_hd] : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      rd_pend   <= 1'b0;
      rd_last_q <= 1'b0;
      rd_nb_q   <= '0;
      buf_cnt   <= '0;
      buf_hd    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
        buf_nb[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      buf_cnt <= '0;
      buf_hd  <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_last_q <= sb_last[rd_ptr[ADDR_W-1:0]];
        rd_nb_q   <= sb_nb[rd_ptr[ADDR_W-1:0]];
      end
      // The slot behind the current entries; with at most one entry held
      // when data lands, this never collides with the head.
      if (rd_pend) begin
        buf_data[buf_hd ^ buf_cnt[0]] <= ram_rd_data;
        buf_last[buf_hd ^ buf_cnt[0]] <= rd_last_q;
        buf_nb[buf_hd ^ buf_cnt[0]]   <= rd_nb_q;
      end
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
      buf_hd  <= buf_hd ^ pop;
    end
  end

endmodule

// File: tb/tb_rx_ring_ctrl.sv
`timescale 1ns/1ps
module tb_rx_ring_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 48;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 32;
  localparam int BE_W   = 6;
  localparam int EW     = DATA_W + 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic [2:0]        in_nbytes = 3'd0;
  logic              in_err = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [2:0]        out_nbytes;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [BE_W-1:0]   ram_wr_be;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [ADDR_W:0]   level;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  ovf_cnt;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  rx_ring_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_nbytes(out_nbytes),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_be(ram_wr_be), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .level(level), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt), .dbg_state(dbg_state)
  );

  // RX_RING model: byte-enabled write, 1-cycle read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < BE_W; b++)
        if (ram_wr_be[b]) mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    ram_rd_data <= mem[ram_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0]     exp_q[$];      // {last, nbytes, data}
  logic [DATA_W-1:0] cur_q[$];      // words of the frame being received
  bit                m_dropping = 1'b0;
  int                m_drop = 0;
  int                m_ovf = 0;
  int                rdy_mode = 0;  // 0 hold low, 1 hold high, 2 random
  int                pop_cyc_q[$];
  int                first_valid_cyc = -1;
  int                max_level = 0;
  int                last_acc_cyc = 0;
  int                total_waits = 0;

  function automatic logic [DATA_W-1:0] rnd_word();
    return DATA_W'({$urandom, $urandom});
  endfunction

  function automatic void model_accept(input logic [DATA_W-1:0] d, input logic l,
                                       input logic [2:0] nb, input logic e);
    logic       lb;
    logic [2:0] nv;
    if (m_dropping) begin
      if (l) m_dropping = 1'b0;
      return;
    end
    cur_q.push_back(d);
    if (cur_q.size() > DEPTH) begin
      if (m_ovf < 65535) m_ovf++;
      cur_q.delete();
      m_dropping = !l;
      return;
    end
    if (l) begin
      if (e) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        for (int i = 0; i < cur_q.size(); i++) begin
          lb = (i == cur_q.size() - 1);
          nv = lb ? nb : 3'd6;
          exp_q.push_back({lb, nv, cur_q[i]});
        end
      end
      cur_q.delete();
    end
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    cur_q.delete();
    m_dropping = 1'b0;
  endfunction

  function automatic void model_reset();
    model_flush();
    m_drop = 0;
    m_ovf = 0;
  endfunction

  // Output monitor: picks out_ready, then checks every handshake against exp_q.
  logic [EW-1:0]     mon_e;
  logic [DATA_W-1:0] mon_mask;
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (rst_n) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready && !flush) begin
        pop_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got data=%h last=%0b exp=no word", out_data, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          for (int b = 0; b < BE_W; b++)
            mon_mask[b*8 +: 8] = (b < int'(mon_e[EW-2:EW-4])) ? 8'hff : 8'h00;
          if (((out_data & mon_mask) !== (mon_e[DATA_W-1:0] & mon_mask)) ||
              (out_last !== mon_e[EW-1]) || (out_nbytes !== mon_e[EW-2:EW-4])) begin
            failures++;
            $display("FAIL out_word got data=%h last=%0b nb=%0d exp data=%h last=%0b nb=%0d",
                     out_data & mon_mask, out_last, out_nbytes,
                     mon_e[DATA_W-1:0] & mon_mask, mon_e[EW-1], mon_e[EW-2:EW-4]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input logic [2:0] nb,
                           input logic e, input int gap);
    int              waits;
    logic            exp_wr;
    logic [BE_W-1:0] exp_be;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = nb; in_err = e;
    waits = 0;
    #1;
    while (!in_ready && waits < 2000) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got in_ready=0 after %0d cycles exp=1", waits);
      in_valid = 1'b0;
      return;
    end
    total_waits += waits;
    exp_wr = !m_dropping && (cur_q.size() < DEPTH);
    checks++;
    if (ram_wr_en !== exp_wr) begin
      failures++;
      $display("FAIL ram_wr_en got=%0b exp=%0b", ram_wr_en, exp_wr);
    end
    if (exp_wr) begin
      exp_be = '1;
      if (l) for (int b = 0; b < BE_W; b++) exp_be[b] = (b < int'(nb));
      checks++;
      if ((ram_wr_be !== exp_be) || (ram_wr_data !== d)) begin
        failures++;
        $display("FAIL ram_wr_port got be=%b data=%h exp be=%b data=%h", ram_wr_be, ram_wr_data, exp_be, d);
      end
    end
    @(posedge clk);
    model_accept(d, l, nb, e);
    #1;
    last_acc_cyc = cyc;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    ok = (exp_q.size() == 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rdy_mode = 0;
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b1, 3'd3, 1'b1, 0);
    send_word(rnd_word(), 1'b1, 3'd4, 1'b0, 0);
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    drive_idle();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_out_valid got=%0b exp=1", out_valid); end
    checks++;
    if (drop_cnt !== CNT_W'(m_drop)) begin failures++; $display("FAIL pre_reset_drop_cnt got=%0d exp=%0d", drop_cnt, m_drop); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_nbytes !== 3'd0) begin
      failures++; $display("FAIL reset_out got valid=%0b last=%0b nb=%0d exp 0/0/0", out_valid, out_last, out_nbytes);
    end
    checks++;
    if (level !== '0 || ram_wr_en !== 1'b0) begin failures++; $display("FAIL reset_level got level=%0d wr_en=%0b exp 0/0", level, ram_wr_en); end
    checks++;
    if (drop_cnt !== CNT_W'(m_drop) || ovf_cnt !== CNT_W'(m_ovf)) begin
      failures++; $display("FAIL reset_counters got drop=%0d ovf=%0d exp %0d/%0d", drop_cnt, ovf_cnt, m_drop, m_ovf);
    end
    checks++;
    if (dut.wr_ptr !== '0 || dut.cmt_ptr !== '0 || dut.rd_ptr !== '0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL reset_pointers got wr=%0d cmt=%0d rd=%0d st=%0d exp all 0",
                           dut.wr_ptr, dut.cmt_ptr, dut.rd_ptr, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    bit ok;
    int c_cyc;
    rdy_mode = 1;
    pop_cyc_q.delete();
    first_valid_cyc = -1;
    send_word(rnd_word(), 1'b0, 3'd5, 1'b0, 0);
    send_word(rnd_word(), 1'b0, 3'd1, 1'b0, 0);
    send_word(rnd_word(), 1'b1, 3'd2, 1'b0, 0);
    c_cyc = last_acc_cyc;
    drive_idle();
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL good_drain got %0d left exp 0", exp_q.size()); end
    checks++;
    if (first_valid_cyc !== c_cyc + 2) begin
      failures++; $display("FAIL good_latency got edge=%0d exp edge=%0d", first_valid_cyc, c_cyc + 2);
    end
    checks++;
    if (!(pop_cyc_q.size() == 3 && pop_cyc_q[2] - pop_cyc_q[0] == 2)) begin
      failures++; $display("FAIL good_consecutive got pops=%0d exp 3 back-to-back", pop_cyc_q.size());
    end
  endtask

  task automatic test_error_frame();
    bit ok;
    rdy_mode = 1;
    pop_cyc_q.delete();
    max_level = 0;
    for (int i = 0; i < 4; i++)
      send_word(rnd_word(), (i == 3), 3'($urandom_range(1, 6)), (i == 3), 0);
    send_word(rnd_word(), 1'b1, 3'd6, 1'b0, 0);
    drive_idle();
    wait_drain(ok);
    checks++;
    if (!ok || pop_cyc_q.size() != 1) begin
      failures++; $display("FAIL err_output got pops=%0d left=%0d exp 1/0", pop_cyc_q.size(), exp_q.size());
    end
    checks++;
    if (drop_cnt !== CNT_W'(m_drop)) begin failures++; $display("FAIL err_drop_cnt got=%0d exp=%0d", drop_cnt, m_drop); end
    checks++;
    if (max_level > 1) begin failures++; $display("FAIL err_level_max got=%0d exp<=1", max_level); end
  endtask

  task automatic test_overflow();
    bit ok;
    rdy_mode = 1;
    pop_cyc_q.delete();
    total_waits = 0;
    for (int i = 0; i < 40; i++)
      send_word(rnd_word(), (i == 39), 3'd6, 1'b0, 0);
    drive_idle();
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (ovf_cnt !== CNT_W'(m_ovf)) begin failures++; $display("FAIL ovf_cnt got=%0d exp=%0d", ovf_cnt, m_ovf); end
    checks++;
    if (total_waits != 0) begin failures++; $display("FAIL ovf_in_ready got stall_cycles=%0d exp 0", total_waits); end
    checks++;
    if (pop_cyc_q.size() != 0 || level !== '0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL ovf_quiet got pops=%0d level=%0d st=%0d exp 0/0/0", pop_cyc_q.size(), level, dbg_state);
    end
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b1, 3'd4, 1'b0, 0);
    drive_idle();
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovf_recover got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_full();
    bit ok;
    rdy_mode = 0;
    total_waits = 0;
    // RAM holds DEPTH words; the stalled output buffer holds two more.
    for (int i = 0; i < DEPTH + 2; i++)
      send_word(rnd_word(), 1'b1, 3'($urandom_range(1, 6)), 1'b0, 0);
    drive_idle();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (in_ready !== 1'b0 || total_waits != 0) begin
      failures++; $display("FAIL full_in_ready got=%0b stalls=%0d exp 0/0", in_ready, total_waits);
    end
    checks++;
    if (int'(level) != DEPTH || out_valid !== 1'b1) begin
      failures++; $display("FAIL full_level got level=%0d valid=%0b exp %0d/1", level, out_valid, DEPTH);
    end
    @(negedge clk); #3;
    pop_cyc_q.delete();
    rdy_mode = 1;
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_drain got %0d left exp 0", exp_q.size()); end
    checks++;
    if (!(pop_cyc_q.size() == DEPTH + 2 && pop_cyc_q[DEPTH+1] - pop_cyc_q[0] == DEPTH + 1)) begin
      failures++; $display("FAIL full_rate got pops=%0d exp %0d back-to-back", pop_cyc_q.size(), DEPTH + 2);
    end
  endtask

  task automatic test_flush();
    bit ok;
    rdy_mode = 0;
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b1, 3'd3, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_word(rnd_word(), (i == 2), 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    send_word(rnd_word(), 1'b0, 3'd6, 1'b0, 0);
    drive_idle();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== '0) begin
      failures++; $display("FAIL flush_clear got valid=%0b level=%0d exp 0/0", out_valid, level);
    end
    checks++;
    if (drop_cnt !== CNT_W'(m_drop) || ovf_cnt !== CNT_W'(m_ovf) || dbg_state !== 2'd0) begin
      failures++; $display("FAIL flush_keep got drop=%0d ovf=%0d st=%0d exp %0d/%0d/0", drop_cnt, ovf_cnt, dbg_state, m_drop, m_ovf);
    end
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_word(rnd_word(), (i == 2), 3'd5, 1'b0, 0);
    drive_idle();
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL flush_after got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        send_word(rnd_word(), (i == len - 1), 3'($urandom_range(1, 6)),
                  (i == len - 1) && ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end
    drive_idle();
    wait_drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rand_drain got %0d left exp 0", exp_q.size()); end
    checks++;
    if (drop_cnt !== CNT_W'(m_drop) || ovf_cnt !== CNT_W'(m_ovf) || level !== '0) begin
      failures++; $display("FAIL rand_stats got drop=%0d ovf=%0d level=%0d exp %0d/%0d/0", drop_cnt, ovf_cnt, level, m_drop, m_ovf);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_good_frame();
    test_error_frame();
    test_overflow();
    test_full();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
